// File: rtl/snake_vga_pkg.sv
// Shared definitions for the snake VGA path: tile codes, scheduler state encodings
// and default board geometry.
package snake_vga_pkg;

  localparam int unsigned DEF_MAX_SEGS = 100;
  localparam int unsigned DEF_GRID_W   = 10;
  localparam int unsigned DEF_GRID_H   = 10;
  localparam int unsigned DEF_COORD_W  = 32;

  typedef logic [1:0] tile_code_t;

  localparam tile_code_t TILE_EMPTY = 2'd0;
  localparam tile_code_t TILE_BODY  = 2'd1;
  localparam tile_code_t TILE_HEAD  = 2'd2;
  localparam tile_code_t TILE_FOOD  = 2'd3;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StWalk  = 3'd2;
  localparam logic [2:0] StFood  = 3'd3;
  localparam logic [2:0] StSwap  = 3'd4;

endpackage

// File: rtl/tile_map_bank.sv
// One tile-occupancy bank: flop array with a write port, a combinational read port used
// for read-modify-write while building, and a registered read port for the renderer.
module tile_map_bank
  import snake_vga_pkg::*;
#(
  parameter int unsigned DEPTH = 100,
  parameter int unsigned AW    = 7
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  tile_code_t      wdata,
  input  logic [AW-1:0]   rmw_addr,
  output tile_code_t      rmw_data,
  input  logic [AW-1:0]   rd_addr,
  output tile_code_t      rd_data
);

  tile_code_t mem [DEPTH];

  // Contents are deliberately not reset; every build starts with a full clear pass.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rd_data <= mem[rd_addr];
  end

  assign rmw_data = mem[rmw_addr];

endmodule

// File: rtl/snake_tile_map_scheduler.sv
// Per-frame builder of a double-buffered tile-occupancy map from the snake segment arrays
// and food position, with a registered lookup port for the pixel renderer.
module snake_tile_map_scheduler
  import snake_vga_pkg::*;
#(
  parameter int unsigned MAX_SEGS = DEF_MAX_SEGS,
  parameter int unsigned GRID_W   = DEF_GRID_W,
  parameter int unsigned GRID_H   = DEF_GRID_H,
  parameter int unsigned COORD_W  = DEF_COORD_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic [MAX_SEGS*COORD_W-1:0]   x_values,
  input  logic [MAX_SEGS*COORD_W-1:0]   y_values,
  input  logic [COORD_W-1:0]            food_x,
  input  logic [COORD_W-1:0]            food_y,
  input  logic [$clog2(GRID_W)-1:0]     rd_tile_x,
  input  logic [$clog2(GRID_H)-1:0]     rd_tile_y,
  output logic [1:0]                    rd_code,
  output logic                          busy,
  output logic                          map_valid,
  output logic                          frame_done,
  output logic                          self_collision,
  output logic                          food_on_snake,
  output logic                          oob_seen,
  output logic                          overrun
);

  localparam int unsigned DEPTH = GRID_W * GRID_H;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned SW    = (MAX_SEGS > 1) ? $clog2(MAX_SEGS) : 1;
  localparam int unsigned XW    = $clog2(GRID_W);
  localparam int unsigned YW    = $clog2(GRID_H);

  logic [2:0]         state_q, state_d;
  logic [AW-1:0]      clr_q;
  logic [SW-1:0]      seg_q;
  logic [COORD_W-1:0] food_x_q, food_y_q;
  logic               front_sel_q;
  logic               coll_acc_q, food_acc_q, oob_acc_q;
  logic               self_collision_q, food_on_snake_q, oob_seen_q;
  logic               map_valid_q, frame_done_q;
  logic               rd_ok_q, rd_sel_q;

  logic [COORD_W-1:0] seg_x, seg_y, cur_x, cur_y;
  logic               seg_absent, cur_in;
  logic [AW-1:0]      cur_idx, rd_idx;
  logic               rd_in;
  logic               we;
  logic [AW-1:0]      waddr;
  tile_code_t         wdata;
  logic               set_coll, set_food, set_oob;
  tile_code_t         rmw0, rmw1, back_rmw;
  tile_code_t         rd0, rd1;

  assign seg_x      = x_values[COORD_W*seg_q +: COORD_W];
  assign seg_y      = y_values[COORD_W*seg_q +: COORD_W];
  assign seg_absent = (&seg_x) || (&seg_y);

  // The walk and the food step share one coordinate path into the RMW port.
  assign cur_x   = (state_q == StFood) ? food_x_q : seg_x;
  assign cur_y   = (state_q == StFood) ? food_y_q : seg_y;
  assign cur_in  = (cur_x < COORD_W'(GRID_W)) && (cur_y < COORD_W'(GRID_H));
  assign cur_idx = cur_in ? (AW'(cur_y[YW-1:0]) * AW'(GRID_W) + AW'(cur_x[XW-1:0])) : '0;

  assign rd_in  = (32'(rd_tile_x) < GRID_W) && (32'(rd_tile_y) < GRID_H);
  assign rd_idx = rd_in ? (AW'(rd_tile_y) * AW'(GRID_W) + AW'(rd_tile_x)) : '0;

  // The back bank is the one not selected by front_sel.
  assign back_rmw = front_sel_q ? rmw0 : rmw1;

  always_comb begin
    state_d  = state_q;
    we       = 1'b0;
    waddr    = cur_idx;
    wdata    = TILE_EMPTY;
    set_coll = 1'b0;
    set_food = 1'b0;
    set_oob  = 1'b0;
    case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StClear;
        end
      end
      StClear: begin
        we    = 1'b1;
        waddr = clr_q;
        if (clr_q == AW'(DEPTH - 1)) begin
          state_d = StWalk;
        end
      end
      StWalk: begin
        if (!seg_absent) begin
          if (!cur_in) begin
            set_oob = 1'b1;
          end else if (seg_q == '0) begin
            we    = 1'b1;
            wdata = TILE_HEAD;
          end else if (back_rmw == TILE_EMPTY) begin
            we    = 1'b1;
            wdata = TILE_BODY;
          end else begin
            set_coll = 1'b1;
          end
        end
        if (seg_q == SW'(MAX_SEGS - 1)) begin
          state_d = StFood;
        end
      end
      StFood: begin
        if (!cur_in) begin
          set_oob = 1'b1;
        end else if (back_rmw == TILE_EMPTY) begin
          we    = 1'b1;
          wdata = TILE_FOOD;
        end else begin
          set_food = 1'b1;
        end
        state_d = StSwap;
      end
      StSwap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= StIdle;
      clr_q            <= '0;
      seg_q            <= '0;
      food_x_q         <= '0;
      food_y_q         <= '0;
      front_sel_q      <= 1'b0;
      coll_acc_q       <= 1'b0;
      food_acc_q       <= 1'b0;
      oob_acc_q        <= 1'b0;
      self_collision_q <= 1'b0;
      food_on_snake_q  <= 1'b0;
      oob_seen_q       <= 1'b0;
      map_valid_q      <= 1'b0;
      frame_done_q     <= 1'b0;
      rd_ok_q          <= 1'b0;
      rd_sel_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= (state_q == StSwap);
      // Lookup qualification is captured alongside the bank read so SWAP-cycle lookups see
      // the old front.
      rd_ok_q      <= map_valid_q && rd_in;
      rd_sel_q     <= front_sel_q;

      if ((state_q == StIdle) && frame_start) begin
        clr_q      <= '0;
        seg_q      <= '0;
        food_x_q   <= food_x;
        food_y_q   <= food_y;
        coll_acc_q <= 1'b0;
        food_acc_q <= 1'b0;
        oob_acc_q  <= 1'b0;
      end else begin
        if (set_coll) coll_acc_q <= 1'b1;
        if (set_food) food_acc_q <= 1'b1;
        if (set_oob)  oob_acc_q  <= 1'b1;
      end

      if (state_q == StClear) clr_q <= clr_q + 1'b1;
      if (state_q == StWalk)  seg_q <= seg_q + 1'b1;

      if (state_q == StSwap) begin
        front_sel_q      <= ~front_sel_q;
        self_collision_q <= coll_acc_q;
        food_on_snake_q  <= food_acc_q;
        oob_seen_q       <= oob_acc_q;
        map_valid_q      <= 1'b1;
      end
    end
  end

  tile_map_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank0 (
    .clk      (clk),
    .we       (we && front_sel_q),
    .waddr    (waddr),
    .wdata    (wdata),
    .rmw_addr (cur_idx),
    .rmw_data (rmw0),
    .rd_addr  (rd_idx),
    .rd_data  (rd0)
  );

  tile_map_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank1 (
    .clk      (clk),
    .we       (we && !front_sel_q),
    .waddr    (waddr),
    .wdata    (wdata),
    .rmw_addr (cur_idx),
    .rmw_data (rmw1),
    .rd_addr  (rd_idx),
    .rd_data  (rd1)
  );

  assign rd_code        = rd_ok_q ? (rd_sel_q ? rd1 : rd0) : TILE_EMPTY;
  assign busy           = (state_q != StIdle);
  assign overrun        = frame_start && busy;
  assign map_valid      = map_valid_q;
  assign frame_done     = frame_done_q;
  assign self_collision = self_collision_q;
  assign food_on_snake  = food_on_snake_q;
  assign oob_seen       = oob_seen_q;

endmodule
